// File: rtl/uart_tx.sv
// uart_tx: 8N1-style UART transmitter with one-deep holding register, driven by a baud tick.
//   Parameters: DATA_BITS (5..8, LSB first), STOP_BITS (1 or 2).
//   Ports:
//     clk       system clock
//     rst       asynchronous active-high reset
//     baud_tick one-cycle pulse per bit period
//     tx_data   byte to send, captured on accept
//     tx_valid  upstream has data
//     tx_ready  holding register empty (accept on tx_valid && tx_ready)
//     tx        serial line, idle high
//     busy      frame in progress or byte held
//   Optional: define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = $clog2(DATA_BITS);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_q, par_d;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d, shift_q, shift_d;
    logic                 hold_full_q, hold_full_d, tx_q, tx_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 stop_last, load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        stop_last   = stop_cnt_q == 1'(STOP_BITS - 1);
        // A held byte launches from IDLE or straight off the final stop tick (no idle gap).
        load        = baud_tick && hold_full_q && (state_q == IDLE || (state_q == STOP && stop_last));
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (baud_tick) begin
            case (state_q)
                START: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                        stop_cnt_d = 1'b0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    if (stop_last) state_d = IDLE;
                    else stop_cnt_d = stop_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = START;
`ifdef UART_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ~hold_full_q;
    assign busy     = (state_q != IDLE) || hold_full_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for two uart_tx instances (STOP_BITS=1 and STOP_BITS=2).
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    typedef struct {
        logic [7:0] d;
        int         s;
    } fr_t;

    logic       clk = 1'b0, rst = 1'b1, baud_tick = 1'b0;
    logic [7:0] tx_data [2];
    logic [1:0] tx_valid = '0, rdy, txo, bsy;
    int         tick_n = 0, tick_per = 4, freeze = 0;
    int         last_s [2] = '{-1000, -1000};
    logic [1:0] acc = '0;
    fr_t        q0[$], q1[$], nf;
    logic [7:0] cur_d [2];
    int         cur_s [2];
    logic [1:0] cur_v = '0, busy_e = '0;
    int         pos_r [2];
    int         checks = 0, passes = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        uart_tx #(.DATA_BITS(8), .STOP_BITS(g + 1)) dut (
            .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data[g]),
            .tx_valid(tx_valid[g]), .tx_ready(rdy[g]), .tx(txo[g]), .busy(bsy[g])
        );
    end

    // frame length in ticks: start + 8 data + optional parity + stop bits
    function automatic int fl(input int i);
        return 10 + i + PAR;
    endfunction

    function automatic logic ebit(input logic [7:0] d, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
        if (PAR == 1 && p == 9) return ^d;
        return 1'b1;
    endfunction

    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            c++;
            baud_tick = (freeze == 0) && (c % tick_per == 0);
        end
    end

    // Reference model: a byte accepted at an edge starts on the first later tick,
    // but never before the previous frame on that line has fully finished.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            last_s = '{-1000, -1000};
            acc    = '0;
        end else begin
            if (baud_tick) tick_n++;
            for (int i = 0; i < 2; i++) begin
                acc[i] = tx_valid[i] && ((i == 0 ? q0.size() : q1.size()) == 0);
                if (acc[i]) begin
                    nf.d = tx_data[i];
                    nf.s = (tick_n + 1 > last_s[i] + fl(i)) ? tick_n + 1 : last_s[i] + fl(i);
                    last_s[i] = nf.s;
                    if (i == 0) q0.push_back(nf);
                    else q1.push_back(nf);
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic a, input logic e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s cfg%0d t=%0t: got %b want %b", nm, i, $time, a, e);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                chk("rst_tx", i, txo[i], 1'b1);
                chk("rst_ready", i, rdy[i], 1'b1);
                chk("rst_busy", i, bsy[i], 1'b0);
                cur_v[i]  = 1'b0;
                busy_e[i] = 1'b0;
                if (i == 0) q0.delete();
                else q1.delete();
            end else begin
                if (i == 0 && q0.size() > 0 && q0[0].s <= tick_n) begin
                    nf = q0.pop_front();
                    cur_d[0] = nf.d; cur_s[0] = nf.s; cur_v[0] = 1'b1;
                end
                if (i == 1 && q1.size() > 0 && q1[0].s <= tick_n) begin
                    nf = q1.pop_front();
                    cur_d[1] = nf.d; cur_s[1] = nf.s; cur_v[1] = 1'b1;
                end
                pos_r[i]  = tick_n - cur_s[i];
                busy_e[i] = ((i == 0 ? q0.size() : q1.size()) != 0) || (cur_v[i] && pos_r[i] < fl(i));
                chk("tx", i, txo[i], (cur_v[i] && pos_r[i] < fl(i)) ? ebit(cur_d[i], pos_r[i]) : 1'b1);
                chk("tx_ready", i, rdy[i], (i == 0 ? q0.size() : q1.size()) == 0);
                chk("busy", i, bsy[i], busy_e[i]);
            end
        end
    end

    task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
        tx_data[0] = b0;
        tx_data[1] = b1;
        tx_valid   = 2'b11;
        for (int n = 0; n < 5000 && tx_valid != 0; n++) begin
            @(posedge clk);
            #1;
            tx_valid = tx_valid & ~acc;
        end
        if (tx_valid != 0) begin
            $display("FAIL send_timeout: got valid %b want 00", tx_valid);
            $fatal(1);
        end
    endtask

    task automatic wait_idle;
        @(negedge clk);
        for (int n = 0; n < 5000 && busy_e != 0; n++) @(negedge clk);
        if (busy_e != 0) begin
            $display("FAIL idle_timeout: got busy %b want 00", busy_e);
            $fatal(1);
        end
    endtask

    task automatic wait_pos(input int p);
        for (int n = 0; n < 5000 && !(cur_v[0] && pos_r[0] == p); n++) @(negedge clk);
        if (!(cur_v[0] && pos_r[0] == p)) begin
            $display("FAIL pos_timeout: got %0d want %0d", pos_r[0], p);
            $fatal(1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        send2(8'h55, 8'h55);
        wait_idle();
        send2(8'hA5, 8'h00);
        send2(8'h3C, 8'h00);
        send2(8'h99, 8'hFF);
        wait_idle();
        send2(8'h0F, 8'h0F);
        send2(8'h77, 8'h77);
        wait_pos(4);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        send2(8'hC3, 8'h5A);
        wait_pos(3);
        freeze = 1;
        repeat (100) @(negedge clk);
        freeze = 0;
        wait_idle();
        send2(8'h07, 8'h07);
        send2(8'h03, 8'h03);
        wait_idle();
        for (int k = 0; k < 40; k++) begin
            tick_per = $urandom_range(1, 5);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send2(8'($urandom), 8'($urandom));
        end
        wait_idle();
        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
